// File: rtl/pconfigp_bank.sv
// Bank of NREG parity-protected config registers behind one addressed uP port.
// Optional background parity scrubber enabled by defining PCFGB_SCRUB_EN.
module pconfigp_bank #(
  parameter int WIDTH = 8,
  parameter int NREG = 4,
  parameter int ADDRW = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  upen,
  input  logic                  upws,
  input  logic [ADDRW-1:0]      upa,
  input  logic [WIDTH-1:0]      updi,
  output logic [WIDTH-1:0]      updo,
  output logic                  upack,
  output logic [NREG*WIDTH-1:0] out,
  input  logic                  par_dis,
  output logic [NREG-1:0]       par_err,
  input  logic                  err_clr,
  output logic                  err_sticky,
  output logic [ADDRW-1:0]      err_addr
);

  function automatic logic parity_f(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  localparam logic             RESET_PAR = ^RESET_VALUE;
  localparam logic [ADDRW:0]   NREG_W    = (ADDRW+1)'(NREG);

  logic [WIDTH-1:0] regs_r [NREG];
  logic [NREG-1:0]  par_r;
  logic [WIDTH-1:0] updo_r;
  logic             upack_r;
  logic             err_sticky_r;
  logic [ADDRW-1:0] err_addr_r;

  logic             in_range_s;
  logic             wr_en_s;
  logic             rd_en_s;
  logic [WIDTH-1:0] rd_data_s;
  logic [NREG-1:0]  par_err_s;
  logic             det_s;
  logic [ADDRW-1:0] det_idx_s;

  assign in_range_s = ({1'b0, upa} < NREG_W);
  assign wr_en_s    = upen & upws & in_range_s;
  assign rd_en_s    = upen & ~upws & in_range_s;

  // Register file and parity bits; par_dis freezes parity for error injection.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= RESET_VALUE;
        par_r[i]  <= RESET_PAR;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_en_s && (upa == ADDRW'(i))) begin
          regs_r[i] <= updi;
          if (!par_dis) begin
            par_r[i] <= parity_f(updi);
          end
        end
      end
    end
  end

  // Read mux; out-of-range addresses match no register and yield zero.
  always_comb begin
    rd_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      rd_data_s = (upa == ADDRW'(i)) ? regs_r[i] : rd_data_s;
    end
  end

  // Live parity check per register.
  always_comb begin
    par_err_s = {NREG{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      par_err_s[i] = par_r[i] ^ parity_f(regs_r[i]);
    end
  end

`ifdef PCFGB_SCRUB_EN
  logic [ADDRW-1:0] scan_r;

  // Scan index walks 0..NREG-1 one step per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_r <= {ADDRW{1'b0}};
    end else if (scan_r == ADDRW'(NREG-1)) begin
      scan_r <= {ADDRW{1'b0}};
    end else begin
      scan_r <= scan_r + {{(ADDRW-1){1'b0}}, 1'b1};
    end
  end

  // Check only the scanned register, skipped when it is being rewritten.
  always_comb begin
    det_s     = 1'b0;
    det_idx_s = scan_r;
    for (int i = 0; i < NREG; i++) begin
      if (scan_r == ADDRW'(i)) begin
        det_s = par_err_s[i] & ~(wr_en_s && (upa == scan_r));
      end else begin
        det_s = det_s;
      end
    end
  end
`else
  // Any live error detects; lowest erroring index is reported.
  always_comb begin
    det_s     = |par_err_s;
    det_idx_s = {ADDRW{1'b0}};
    for (int i = NREG-1; i >= 0; i--) begin
      if (par_err_s[i]) begin
        det_idx_s = ADDRW'(i);
      end else begin
        det_idx_s = det_idx_s;
      end
    end
  end
`endif

  // Sticky error capture; a detection in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_r <= 1'b0;
      err_addr_r   <= {ADDRW{1'b0}};
    end else if (det_s && (!err_sticky_r || err_clr)) begin
      err_sticky_r <= 1'b1;
      err_addr_r   <= det_idx_s;
    end else if (err_clr) begin
      err_sticky_r <= 1'b0;
    end
  end

  // Access acknowledge and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      upack_r <= 1'b0;
      updo_r  <= {WIDTH{1'b0}};
    end else begin
      upack_r <= upen;
      updo_r  <= rd_en_s ? rd_data_s : {WIDTH{1'b0}};
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_out
    assign out[g*WIDTH +: WIDTH] = regs_r[g];
  end

  assign updo       = updo_r;
  assign upack      = upack_r;
  assign par_err    = par_err_s;
  assign err_sticky = err_sticky_r;
  assign err_addr   = err_addr_r;

endmodule

// File: tb/tb_pconfigp_bank.sv
// Bench for pconfigp_bank (default build): a 4-register and a 3-register
// instance share stimulus and are checked against an array-based model.
module tb_pconfigp_bank;

  logic       clk = 1'b0;
  logic       rst, upen, upws, par_dis, err_clr;
  logic [1:0] upa;
  logic [7:0] updi;

  logic [7:0]  updo4, updo3;
  logic        upack4, upack3, sticky4, sticky3;
  logic [31:0] out4;
  logic [23:0] out3;
  logic [3:0]  perr4;
  logic [2:0]  perr3;
  logic [1:0]  eaddr4, eaddr3;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  pconfigp_bank #(.WIDTH(8), .NREG(4), .ADDRW(2)) dut4 (
    .clk(clk), .rst(rst), .upen(upen), .upws(upws), .upa(upa), .updi(updi),
    .updo(updo4), .upack(upack4), .out(out4), .par_dis(par_dis),
    .par_err(perr4), .err_clr(err_clr), .err_sticky(sticky4), .err_addr(eaddr4));

  pconfigp_bank #(.WIDTH(8), .NREG(3), .ADDRW(2)) dut3 (
    .clk(clk), .rst(rst), .upen(upen), .upws(upws), .upa(upa), .updi(updi),
    .updo(updo3), .upack(upack3), .out(out3), .par_dis(par_dis),
    .par_err(perr3), .err_clr(err_clr), .err_sticky(sticky3), .err_addr(eaddr3));

  // Model state, index 0 = 4-register bank, index 1 = 3-register bank.
  int         nr [2] = '{4, 3};
  logic [7:0] m_reg [2][4];
  logic       m_par [2][4];
  logic [7:0] m_updo [2];
  logic       m_ack [2];
  logic       m_sticky [2];
  logic [1:0] m_addr [2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_perr(int k, int i);
    return (^m_reg[k][i]) != m_par[k][i];
  endfunction

  function automatic logic [3:0] m_perr_vec(int k);
    logic [3:0] v = 4'b0000;
    for (int i = 0; i < nr[k]; i++) v[i] = m_perr(k, i);
    return v;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 4; i++) begin
          m_reg[k][i] = 8'h00;
          m_par[k][i] = 1'b0;
        end
        m_updo[k] = 8'h00; m_ack[k] = 1'b0; m_sticky[k] = 1'b0; m_addr[k] = 2'd0;
      end else begin
        logic det = 1'b0;
        int   idx = 0;
        logic inr = (int'(upa) < nr[k]);
        for (int i = nr[k]-1; i >= 0; i--) if (m_perr(k, i)) begin det = 1'b1; idx = i; end
        m_ack[k]  = upen;
        m_updo[k] = (upen && !upws && inr) ? m_reg[k][upa] : 8'h00;
        if (upen && upws && inr) begin
          m_reg[k][upa] = updi;
          if (!par_dis) m_par[k][upa] = ^updi;
        end
        if (det && (!m_sticky[k] || err_clr)) begin
          m_sticky[k] = 1'b1;
          m_addr[k]   = 2'(idx);
        end else if (err_clr) begin
          m_sticky[k] = 1'b0;
        end
      end
    end
  endtask

  // Every-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 4; i++) check("out4", 32'(out4[i*8 +: 8]), 32'(m_reg[0][i]));
      for (int i = 0; i < 3; i++) check("out3", 32'(out3[i*8 +: 8]), 32'(m_reg[1][i]));
      check("updo4", 32'(updo4), 32'(m_updo[0]));
      check("updo3", 32'(updo3), 32'(m_updo[1]));
      check("upack4", 32'(upack4), 32'(m_ack[0]));
      check("upack3", 32'(upack3), 32'(m_ack[1]));
      check("par_err4", 32'(perr4), 32'(m_perr_vec(0)));
      check("par_err3", 32'(perr3), 32'(m_perr_vec(1) & 4'b0111));
      check("sticky4", 32'(sticky4), 32'(m_sticky[0]));
      check("sticky3", 32'(sticky3), 32'(m_sticky[1]));
      check("err_addr4", 32'(eaddr4), 32'(m_addr[0]));
      check("err_addr3", 32'(eaddr3), 32'(m_addr[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic acc(input logic en, input logic ws, input logic [1:0] a, input logic [7:0] d);
    upen = en; upws = ws; upa = a; updi = d;
    tick();
  endtask

  initial begin
    rst = 1'b1; upen = 1'b0; upws = 1'b0; upa = 2'd0; updi = 8'h00;
    par_dis = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    rst = 1'b0;
    check("rst_updo", 32'(updo4), 32'h00);
    check("rst_upack", 32'(upack4), 32'h0);
    check("rst_out", out4, 32'h0);
    check("rst_sticky", 32'(sticky4), 32'h0);

    for (int a = 0; a < 4; a++) begin
      acc(1'b1, 1'b0, 2'(a), 8'h00);
      check("rd_ack", 32'(upack4), 32'h1);
      check("rd_zero", 32'(updo4), 32'h00);
    end
    acc(1'b0, 1'b0, 2'd0, 8'h00);
    check("idle_ack", 32'(upack4), 32'h0);

    acc(1'b1, 1'b1, 2'd2, 8'hA5);
    acc(1'b1, 1'b0, 2'd2, 8'h00);
    check("raw_updo", 32'(updo4), 32'hA5);
    check("raw_mdl", 32'(m_updo[0]), 32'hA5);
    check("raw_ack", 32'(upack4), 32'h1);
    check("out_a5", 32'(out4[23:16]), 32'hA5);
    check("perr_clean", 32'(perr4), 32'h0);

    par_dis = 1'b1;
    acc(1'b1, 1'b1, 2'd1, 8'h01);
    check("perr_inj", 32'(perr4), 32'b0010);
    check("sticky_late", 32'(sticky4), 32'h0);
    par_dis = 1'b0;
    acc(1'b0, 1'b0, 2'd0, 8'h00);
    check("sticky_set", 32'(sticky4), 32'h1);
    check("eaddr_1", 32'(eaddr4), 32'h1);
    check("mdl_eaddr", 32'(m_addr[0]), 32'h1);

    par_dis = 1'b1;
    acc(1'b1, 1'b1, 2'd3, 8'h01);
    par_dis = 1'b0;
    check("perr_two", 32'(perr4), 32'b1010);
    check("oor_ack", 32'(upack3), 32'h1);
    check("oor_perr3", 32'(perr3), 32'b010);
    err_clr = 1'b1;
    acc(1'b0, 1'b0, 2'd0, 8'h00);
    err_clr = 1'b0;
    check("clr_recap", 32'(sticky4), 32'h1);
    check("clr_eaddr", 32'(eaddr4), 32'h1);

    acc(1'b1, 1'b0, 2'd3, 8'h00);
    check("rd3_d4", 32'(updo4), 32'h01);
    check("rd3_d3", 32'(updo3), 32'h00);

    acc(1'b1, 1'b1, 2'd1, 8'h03);
    acc(1'b1, 1'b1, 2'd3, 8'h01);
    err_clr = 1'b1;
    acc(1'b0, 1'b0, 2'd0, 8'h00);
    err_clr = 1'b0;
    check("clr_done", 32'(sticky4), 32'h0);
    check("clr_addr_hold", 32'(eaddr4), 32'h1);
    check("perr_fixed", 32'(perr4), 32'h0);

    upen = 1'b1; upws = 1'b0; upa = 2'd2; rst = 1'b1;
    tick();
    check("mid_rst_ack", 32'(upack4), 32'h0);
    check("mid_rst_updo", 32'(updo4), 32'h00);
    check("mid_rst_out", out4, 32'h0);
    rst = 1'b0;
    acc(1'b0, 1'b0, 2'd0, 8'h00);
    acc(1'b0, 1'b0, 2'd0, 8'h00);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
